fpu_op_sched: RTL and testbench
===============================

# fpu_op_sched

Sequencing controller that shares one floating-point arithmetic datapath (add, sub, mul, div on IEEE-754 single precision) between two requesters. Each requester hands over an opcode and two 32-bit operands with a valid/ready handshake. The block round-robin arbitrates between them, issues the operation to the datapath and waits the op-specific latency. It then returns the result tagged with the requester id on a valid/ready response channel, and short-circuits divide-by-zero without using the datapath.

## Interface
- LAT_ADDSUB, default 2: datapath cycles from dp_start to valid dp_result for add/sub (1..31)
- LAT_MUL, default 3: same, for mul (1..31)
- LAT_DIV, default 12: same, for div (1..31)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this cycle when high with valid
- req0_op / req1_op  in  2  00 add, 01 sub, 10 mul, 11 div
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- dp_start  out  1  one-cycle issue strobe to datapath
- dp_op  out  2  opcode to datapath, held from issue until next issue
- dp_a, dp_b  out  32  operands to datapath, held like dp_op
- dp_result  in  32  datapath output, sampled only at the latency point
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  32  result word
- rsp_id  out  1  requester that issued the op
- rsp_dz  out  1  divide-by-zero flag for this result

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Encoding lives in the package.
- IDLE: reqN_ready = grant==N and not rst (combinational). Accept = reqN_valid & reqN_ready. Capture op, a, b and id.
  - Normal op → ISSUE.
  - op==div with captured b[30:0]==0 → RESP directly with rsp_result={a[31]^b[31],8'hFF,23'h0}, rsp_dz=1. No dp_start.
- ISSUE: dp_start=1 for exactly this cycle. dp_op/dp_a/dp_b are driven from the capture registers. Latency counter loads LAT_x-1 → WAIT.
- WAIT: counter decrements each cycle. In the cycle count==0, capture dp_result into rsp_result and set rsp_dz=0 → RESP.
- RESP: rsp_valid=1; rsp_result, rsp_id and rsp_dz are held stable. On rsp_valid & rsp_ready → IDLE.
- Arbitration: 2-way round-robin with a last-served pointer.
  - Only one valid: that requester is granted.
  - Both valid: the requester other than last-served is granted.
  - The pointer updates only on accept.
  - Reset value last=1, so req0 wins the first tie.
- Requesters hold valid and operands until accepted. Dropping valid before accept is legal and simply loses the grant.
- No NaN/denormal handling: operands pass to the datapath unmodified. Only exact ±0 divisors are intercepted.
- Counter is 5 bits wide. LAT parameters outside 1..31 are illegal and must trigger a simulation $error at elaboration.

## Timing
- Reset values:
  - state IDLE, reqN_ready 0 while rst
  - dp_start 0, dp_op 0, dp_a 0, dp_b 0
  - rsp_valid 0, rsp_result 0, rsp_id 0, rsp_dz 0
  - pointer last=1
- Accept in cycle T:
  - dp_start high in T+1.
  - dp_result sampled at end of T+1+LAT.
  - rsp_valid high from T+2+LAT.
- Divide-by-zero accept in T: rsp_valid high from T+1.
- Response handshake in cycle R: IDLE in R+1. Earliest next accept is R+1. Peak throughput is one op per LAT+3 cycles.
- rsp_ready low stalls in RESP indefinitely. No new accept occurs while the block is not IDLE.
- Reset asserted mid-operation: all state clears immediately and asynchronously. The in-flight op is discarded and no response is produced. Any later dp_result is ignored.
- Simultaneous valid on both inputs in the same cycle as reset release: the grant follows the pointer, so req0 wins.

## Structure
- Shared package fpu_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - FSM state constants
  - FP_W=32 and field positions (sign 31, exponent 30:23, fraction 22:0)
  - the +Inf exponent constant 8'hFF
- One sub-module, fpu_rr_arb: 2-requester round-robin arbiter.
  - Inputs: valid vector, accept strobe. Output: one-hot grant.
  - Owns the last-served pointer.
- Remainder is a single FSM with capture registers and the latency counter in fpu_op_sched.

## Test plan
- req0 add a=32'h3F800000 b=32'h40000000, rsp_ready=1 → dp_start exactly 1 cycle at T+1; rsp_valid at T+4; rsp_result equals dp_result model value; rsp_id=0, rsp_dz=0.
- req1 div a=32'hC0400000 b=32'h80000000 → no dp_start; rsp_valid at T+1; rsp_result=32'h7F800000, rsp_dz=1, rsp_id=1.
- Both requesters continuously valid (mul and sub) → grants alternate 0,1,0,1 over 4 ops; each mul response at T+5, sub at T+4.
- rsp_ready held low 10 cycles in RESP → rsp_valid and outputs stable; both reqN_ready stay 0; on release next accept occurs 1 cycle after the handshake.
- rst pulsed during WAIT of a div → all outputs at reset values within the reset cycle; no response after release; next req0 op completes normally.
- Elaboration with LAT_DIV=32 → simulation $error reported.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants for the FP op scheduler: opcodes, FSM states and IEEE-754 single-precision
// field positions.
package fpu_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;
  localparam int unsigned FRAC_LSB = 0;
  localparam int unsigned CNT_W    = 5;

  localparam logic [EXP_MSB-EXP_LSB:0] EXP_INF = 8'hFF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/fpu_rr_arb.sv
// Two-requester round-robin arbiter; the pointer remembers the last requester served and only
// moves when a grant is actually taken.
module fpu_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = 2'b01;
    if (i_valid[1] && (!i_valid[0] || !r_last)) begin
      o_grant = 2'b10;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/fpu_op_sched.sv
// Shares one FP datapath between two requesters: arbitrate, issue, wait the op latency, respond.
// Divides by +/-0 are answered directly with a signed infinity and never reach the datapath.
module fpu_op_sched
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADDSUB = 2,
  parameter int unsigned LAT_MUL    = 3,
  parameter int unsigned LAT_DIV    = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_op,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_op,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  output logic            dp_start,
  output logic [1:0]      dp_op,
  output logic [FP_W-1:0] dp_a,
  output logic [FP_W-1:0] dp_b,
  input  logic [FP_W-1:0] dp_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [FP_W-1:0] rsp_result,
  output logic            rsp_id,
  output logic            rsp_dz
);

  if (LAT_ADDSUB < 1 || LAT_ADDSUB > 31) begin : g_bad_lat_addsub
    $error("fpu_op_sched: LAT_ADDSUB=%0d outside 1..31", LAT_ADDSUB);
  end
  if (LAT_MUL < 1 || LAT_MUL > 31) begin : g_bad_lat_mul
    $error("fpu_op_sched: LAT_MUL=%0d outside 1..31", LAT_MUL);
  end
  if (LAT_DIV < 1 || LAT_DIV > 31) begin : g_bad_lat_div
    $error("fpu_op_sched: LAT_DIV=%0d outside 1..31", LAT_DIV);
  end

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_op, r_dp_op;
  logic [FP_W-1:0]  r_a, r_b, r_dp_a, r_dp_b, r_rsp_result;
  logic             r_id, r_rsp_dz;
  logic [CNT_W-1:0] r_cnt, w_lat_load;

  logic [1:0]      w_valid, w_grant, w_ready;
  logic            w_accept, w_acc_id, w_acc_dz;
  logic [1:0]      w_acc_op;
  logic [FP_W-1:0] w_acc_a, w_acc_b;

  fpu_rr_arb u_arb (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (w_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_valid  = {req1_valid, req0_valid};
    w_ready  = (r_state == StIdle && !rst) ? w_grant : 2'b00;
    w_accept = |(w_valid & w_ready);
    w_acc_id = w_grant[1];
    w_acc_op = w_acc_id ? req1_op : req0_op;
    w_acc_a  = w_acc_id ? req1_a : req0_a;
    w_acc_b  = w_acc_id ? req1_b : req0_b;
    // Only exact +/-0 divisors are intercepted; the sign bit is ignored here.
    w_acc_dz = (w_acc_op == OP_DIV) && (w_acc_b[EXP_MSB:0] == '0);
  end

  always_comb begin
    unique case (r_op)
      OP_MUL:  w_lat_load = CNT_W'(LAT_MUL - 1);
      OP_DIV:  w_lat_load = CNT_W'(LAT_DIV - 1);
      default: w_lat_load = CNT_W'(LAT_ADDSUB - 1);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = w_acc_dz ? StResp : StIssue;
      StIssue: w_state_nxt = StWait;
      StWait:  if (r_cnt == '0) w_state_nxt = StResp;
      StResp:  if (rsp_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_op         <= OP_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_dp_op      <= OP_ADD;
      r_dp_a       <= '0;
      r_dp_b       <= '0;
      r_rsp_result <= '0;
      r_rsp_dz     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op <= w_acc_op;
        r_a  <= w_acc_a;
        r_b  <= w_acc_b;
        r_id <= w_acc_id;
        if (w_acc_dz) begin
          r_rsp_result <= {w_acc_a[SIGN_BIT] ^ w_acc_b[SIGN_BIT], EXP_INF,
                           {(FRAC_MSB - FRAC_LSB + 1){1'b0}}};
          r_rsp_dz     <= 1'b1;
        end
      end
      if (r_state == StIssue) begin
        r_cnt   <= w_lat_load;
        r_dp_op <= r_op;
        r_dp_a  <= r_a;
        r_dp_b  <= r_b;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          r_rsp_result <= dp_result;
          r_rsp_dz     <= 1'b0;
        end
      end
    end
  end

  // Datapath operands come straight from capture during issue, then stay frozen until next issue.
  always_comb begin
    req0_ready = w_ready[0];
    req1_ready = w_ready[1];
    dp_start   = (r_state == StIssue);
    dp_op      = dp_start ? r_op : r_dp_op;
    dp_a       = dp_start ? r_a : r_dp_a;
    dp_b       = dp_start ? r_b : r_dp_b;
    rsp_valid  = (r_state == StResp);
    rsp_result = r_rsp_result;
    rsp_id     = r_id;
    rsp_dz     = r_rsp_dz;
  end

endmodule

// File: tb/tb_fpu_op_sched.sv
// Bench for fpu_op_sched: reset values, table vectors, round-robin alternation, response stall,
// reset abort and randomized traffic against a transaction-level model with a fake datapath.
module tb_fpu_op_sched;
  import fpu_pkg::*;

  localparam int unsigned LA = 2;
  localparam int unsigned LM = 3;
  localparam int unsigned LD = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        dp_start;
  logic [1:0]  dp_op;
  logic [31:0] dp_a, dp_b, dp_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_id, rsp_dz;

  always #5 clk = ~clk;

  fpu_op_sched #(
    .LAT_ADDSUB (LA),
    .LAT_MUL    (LM),
    .LAT_DIV    (LD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .dp_start   (dp_start),
    .dp_op      (dp_op),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_result  (dp_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_dz     (rsp_dz)
  );

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b10:   return LM;
      2'b11:   return LD;
      default: return LA;
    endcase
  endfunction

  // Stand-in arithmetic: any deterministic mix of op and operands exposes routing errors.
  function automatic logic [31:0] dp_func(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + {30'h0, op};
  endfunction

  // Fake datapath: valid only exactly LAT cycles after the start strobe, garbage otherwise.
  logic [1:0]  m_op = 2'b00;
  logic [31:0] m_a = '0, m_b = '0;
  int          m_age = 0;
  always @(posedge clk) begin
    if (dp_start) begin
      m_op  <= dp_op;
      m_a   <= dp_a;
      m_b   <= dp_b;
      m_age <= 1;
    end else if (m_age > 0 && m_age < 100) begin
      m_age <= m_age + 1;
    end
  end
  always_comb begin
    dp_result = 32'hBAD0_0000 | 32'(m_age);
    if (m_age == lat_of(m_op)) dp_result = dp_func(m_op, m_a, m_b);
  end

  logic        pv  [2];
  logic [1:0]  pop [2];
  logic [31:0] pa  [2];
  logic [31:0] pb  [2];
  int          last_m = 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_reqs();
    req0_valid = pv[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pv[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
  endtask

  function automatic int predict();
    if (pv[0] && pv[1]) return (last_m == 1) ? 0 : 1;
    return pv[0] ? 0 : 1;
  endfunction

  task automatic expect_of(input int g, output int lat, output logic [31:0] res,
                           output logic dz);
    dz = (pop[g] == 2'b11) && ((pb[g] & 32'h7FFF_FFFF) == 32'h0);
    if (dz) begin
      lat = 1;
      res = 32'h7F80_0000 | ((pa[g] ^ pb[g]) & 32'h8000_0000);
    end else begin
      lat = lat_of(pop[g]) + 2;
      res = dp_func(pop[g], pa[g], pb[g]);
    end
  endtask

  task automatic gen(input int r);
    pv[r]  = 1'b1;
    pop[r] = 2'($urandom_range(0, 3));
    pa[r]  = $urandom;
    pb[r]  = $urandom;
    if (pop[r] == 2'b11 && $urandom_range(0, 2) == 0) pb[r] = {1'($urandom_range(0, 1)), 31'h0};
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
  task automatic serve(input int g, input int stall, input int exp_lat,
                       input logic [31:0] exp_res, input logic exp_dz);
    int          c, n_start, start_at;
    logic        busy_rdy, unstable;
    logic [31:0] h_res;
    logic        h_id, h_dz;
    drive_reqs();
    rsp_ready = 1'b0;
    #1;
    chk("req0_ready_grant", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready_grant", 32'(req1_ready), 32'(g == 1));
    last_m = g;
    @(posedge clk);
    pv[g] = 1'b0;
    c = 1; n_start = 0; start_at = 0; busy_rdy = 1'b0;
    @(negedge clk);
    drive_reqs();
    #1;
    while (!rsp_valid && c < 64) begin
      if (dp_start) begin
        n_start++;
        start_at = c;
      end
      busy_rdy = busy_rdy | req0_ready | req1_ready;
      @(negedge clk);
      #1;
      c++;
    end
    chk("rsp_latency", c, exp_lat);
    chk("dp_start_count", n_start, exp_dz ? 0 : 1);
    if (!exp_dz) chk("dp_start_cycle", start_at, 1);
    chk("rsp_result", rsp_result, exp_res);
    chk("rsp_id", 32'(rsp_id), g);
    chk("rsp_dz", 32'(rsp_dz), 32'(exp_dz));
    h_res = rsp_result; h_id = rsp_id; h_dz = rsp_dz; unstable = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      if (!rsp_valid || rsp_result !== h_res || rsp_id !== h_id || rsp_dz !== h_dz) unstable = 1;
      busy_rdy = busy_rdy | req0_ready | req1_ready;
    end
    chk("rsp_hold_stable", 32'(unstable), 32'h0);
    chk("busy_ready_low", 32'(busy_rdy), 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'h0);
  endtask

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    int          lat;
    logic [31:0] res;
    logic        dz;
  } vec_t;

  vec_t tv [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, g;
    logic [31:0] res;
    logic        dz, bad;

    tv[0] = '{0, OP_ADD, 32'h3F80_0000, 32'h4000_0000, 0, LA + 2,
              dp_func(OP_ADD, 32'h3F80_0000, 32'h4000_0000), 1'b0};
    tv[1] = '{1, OP_DIV, 32'hC040_0000, 32'h8000_0000, 0, 1, 32'h7F80_0000, 1'b1};
    tv[2] = '{0, OP_DIV, 32'h3F80_0000, 32'h0000_0000, 2, 1, 32'h7F80_0000, 1'b1};
    tv[3] = '{1, OP_DIV, 32'h0000_0000, 32'h8000_0000, 0, 1, 32'hFF80_0000, 1'b1};
    tv[4] = '{0, OP_MUL, 32'h4040_0000, 32'hC000_0000, 10, LM + 2,
              dp_func(OP_MUL, 32'h4040_0000, 32'hC000_0000), 1'b0};
    tv[5] = '{1, OP_SUB, 32'h1234_5678, 32'h9ABC_DEF0, 1, LA + 2,
              dp_func(OP_SUB, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0};
    tv[6] = '{0, OP_DIV, 32'h3F80_0000, 32'h0000_0001, 0, LD + 2,
              dp_func(OP_DIV, 32'h3F80_0000, 32'h0000_0001), 1'b0};
    tv[7] = '{1, OP_DIV, 32'h4000_0000, 32'h8000_0001, 3, LD + 2,
              dp_func(OP_DIV, 32'h4000_0000, 32'h8000_0001), 1'b0};

    // Reset values with both requesters already asking.
    pv[0] = 1'b1; pop[0] = OP_MUL; pa[0] = 32'h4040_0000; pb[0] = 32'h40A0_0000;
    pv[1] = 1'b1; pop[1] = OP_SUB; pa[1] = 32'h4120_0000; pb[1] = 32'h3F80_0000;
    drive_reqs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 32'h0);
    chk("rst_req1_ready", 32'(req1_ready), 32'h0);
    chk("rst_dp_start", 32'(dp_start), 32'h0);
    chk("rst_dp_op", 32'(dp_op), 32'h0);
    chk("rst_dp_a", dp_a, 32'h0);
    chk("rst_dp_b", dp_b, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_dz", 32'(rsp_dz), 32'h0);

    // Release with both valid: req0 first, then strict alternation.
    @(negedge clk);
    rst = 1'b0;
    last_m = 1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      serve(g, 0, (g == 0) ? LM + 2 : LA + 2, dp_func(pop[g], pa[g], pb[g]), 1'b0);
      pv[g] = 1'b1;
    end
    pv[0] = 1'b0; pv[1] = 1'b0;

    for (int i = 0; i < 8; i++) begin
      pv[0] = 1'b0; pv[1] = 1'b0;
      pv[tv[i].id] = 1'b1; pop[tv[i].id] = tv[i].op;
      pa[tv[i].id] = tv[i].a; pb[tv[i].id] = tv[i].b;
      serve(tv[i].id, tv[i].stall, tv[i].lat, tv[i].res, tv[i].dz);
    end

    // Reset in the middle of a long divide.
    pv[0] = 1'b1; pop[0] = OP_DIV; pa[0] = 32'h3F80_0000; pb[0] = 32'h4000_0000; pv[1] = 1'b0;
    drive_reqs();
    #1;
    chk("abort_accept_ready", 32'(req0_ready), 32'h1);
    @(posedge clk);
    pv[0] = 1'b0;
    repeat (5) @(negedge clk);
    drive_reqs();
    req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("abort_dp_start", 32'(dp_start), 32'h0);
    chk("abort_dp_op", 32'(dp_op), 32'h0);
    chk("abort_dp_a", dp_a, 32'h0);
    chk("abort_dp_b", dp_b, 32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_rsp_result", rsp_result, 32'h0);
    chk("abort_rsp_id", 32'(rsp_id), 32'h0);
    chk("abort_rsp_dz", 32'(rsp_dz), 32'h0);
    chk("abort_req1_ready", 32'(req1_ready), 32'h0);
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b0;
    last_m = 1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid || dp_start) bad = 1'b1;
    end
    chk("abort_no_response", 32'(bad), 32'h0);
    pv[0] = 1'b1; pop[0] = OP_ADD; pa[0] = 32'h4080_0000; pb[0] = 32'h3F00_0000;
    serve(0, 0, LA + 2, dp_func(OP_ADD, 32'h4080_0000, 32'h3F00_0000), 1'b0);

    // Randomized traffic against the transaction-level model.
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 1) == 1) gen(r);
      end
      if (!pv[0] && !pv[1]) gen(int'($urandom_range(0, 1)));
      g = predict();
      expect_of(g, lat, res, dz);
      serve(g, int'($urandom_range(0, 3)), lat, res, dz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
